// File: rtl/mem_pkg.sv
// Shared types and sizes for the data-memory store buffer.
package mem_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Age-ordered search of the store buffer for a load address.
// Returns the youngest valid entry whose address matches.
module sb_fwd_match
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [CW-1:0]     count,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && entries[idx].addr == addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// In-order store buffer between the dual-issue MEM stage and the
// two-port data RAM, with load forwarding from buffered stores.
module mem_store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_en1,
    input  logic              st_en2,
    input  logic              ld_en1,
    input  logic              ld_en2,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic              stall,
    output logic [DATA_W-1:0] ld_data1,
    output logic [DATA_W-1:0] ld_data2,
    output logic              sb_empty,
    output logic              memtoregm,
    output logic              memtoregm2,
    output logic              memwritem,
    output logic              memwritem2,
    output logic [ADDR_W-1:0] aluoutm,
    output logic [ADDR_W-1:0] aluoutm2,
    output logic [DATA_W-1:0] writedatam,
    output logic [DATA_W-1:0] writedatam2,
    input  logic [DATA_W-1:0] readdatam,
    input  logic [DATA_W-1:0] readdatam2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t     mem_q [DEPTH];
    sb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          sb_empty_q, sb_empty_d;

    logic [CW-1:0] nst;
    logic          push;
    logic [1:0]    pop_n;
    logic          drain1, drain2;
    sb_entry_t     wr1, wr2;
    logic [PW-1:0] head1, tail1;

    logic              hit1, hit2;
    logic [DATA_W-1:0] fwd1, fwd2;

    assign head1 = head_q + PW'(1);
    assign tail1 = tail_q + PW'(1);

    // Stall uses the occupancy before this cycle's drain.
    always_comb begin
        nst   = CW'(st_en1) + CW'(st_en2);
        stall = ({1'b0, count_q} + {1'b0, nst}) > (CW+1)'(DEPTH);
        push  = !stall;
    end

    always_comb begin
        drain1 = 1'b0;
        drain2 = 1'b0;
        wr1    = mem_q[head_q];
        wr2    = mem_q[head_q];
        pop_n  = 2'd0;
        if (count_q != '0) begin
            if (!ld_en1 && !ld_en2) begin
                drain1 = 1'b1;
                pop_n  = 2'd1;
                if (count_q >= CW'(2)) begin
                    drain2 = 1'b1;
                    wr2    = mem_q[head1];
                    pop_n  = 2'd2;
                end
            end else if (!ld_en1) begin
                drain1 = 1'b1;
                pop_n  = 2'd1;
            end else if (!ld_en2) begin
                drain2 = 1'b1;
                pop_n  = 2'd1;
            end
        end
    end

    always_comb begin
        memtoregm   = ld_en1;
        memtoregm2  = ld_en2;
        memwritem   = rst_n & drain1;
        memwritem2  = rst_n & drain2;
        aluoutm     = drain1 ? wr1.addr : addr1;
        aluoutm2    = drain2 ? wr2.addr : addr2;
        writedatam  = drain1 ? wr1.data : '0;
        writedatam2 = drain2 ? wr2.data : '0;
    end

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (addr1),
        .hit     (hit1),
        .data    (fwd1)
    );

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (addr2),
        .hit     (hit2),
        .data    (fwd2)
    );

    // Lane1 is older, so its same-cycle store beats the buffer for lane2.
    always_comb begin
        ld_data1 = '0;
        ld_data2 = '0;
        if (ld_en1) begin
            ld_data1 = hit1 ? fwd1 : readdatam;
        end
        if (ld_en2) begin
            if (st_en1 && addr1 == addr2) begin
                ld_data2 = wdata1;
            end else begin
                ld_data2 = hit2 ? fwd2 : readdatam2;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push && st_en1) begin
            mem_d[tail_q] = '{addr: addr1, data: wdata1};
        end
        if (push && st_en2) begin
            mem_d[st_en1 ? tail1 : tail_q] = '{addr: addr2, data: wdata2};
        end
        tail_d     = push ? tail_q + PW'(nst) : tail_q;
        head_d     = head_q + PW'(pop_n);
        count_d    = count_q + (push ? nst : '0) - CW'(pop_n);
        sb_empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            sb_empty_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            sb_empty_q <= sb_empty_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign sb_empty = sb_empty_q;

endmodule
